integer_exp_range_reduce: RTL
=============================

# integer_exp_range_reduce

Range-reduction front end of the integer exponential in the attention softmax path. It takes a non-positive softmax logit `q` at scale `S` and decomposes it as `q = p - z*q_ln2`, where `q_ln2 = floor(LN2_FX / S)`. It hands `p` and `S` to `integer_polynomial`, and hands `z` (the final right-shift amount) to the exp output stage. Its `done` pulse drives the polynomial's `start` directly.

## Interface
- `WQ`, default 32: width of `q`, `q_out`.
- `WS`, default 16: width of `S`, `S_out` (Q8.8 scale, 256 = 1.0).
- `LN2_FX`, default 177: ln2 in Q8.8.
- `Z_MAX`, default 30: largest legal shift.
- `clk`, input, 1: clock. One clock domain; all logic is rising-edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: request. Accepted only in IDLE.
- `q`, input, `WQ`, signed: logit after max subtraction.
- `S`, input, `WS`, signed: input scale.
- `q_out`, output, `WQ`, signed: `p`, with range (-q_ln2, 0].
- `S_out`, output, `WS`, signed: `S` passthrough.
- `z_out`, output, 5: shift amount.
- `done`, output, 1: one-cycle result strobe.
- `busy`, output, 1: high from start acceptance through the DONE cycle.
- `err`, output, 1: result invalid (`S<=0` or `q_ln2==0`).
- `sat`, output, 1: `z` clipped to `Z_MAX`.

## Operation
- **Capture.** On accepted `start`:
  - latch `q` and `S`;
  - clamp `q>0` to 0 (softmax inputs are non-positive by contract).
- **States.** IDLE, LN2DIV, QDIV, FIX, DONE. Transitions:
  - IDLE→LN2DIV on `start` with `S>0` and the q_ln2 cache missing.
  - IDLE→QDIV on `start` with the cache hit (cache valid and `S` equals the cached `S`).
  - IDLE→DONE on `start` with `S<=0`, setting `err`.
  - LN2DIV→QDIV after 16 iterations, or LN2DIV→DONE with `err` if the quotient is 0.
  - QDIV→FIX after 32 iterations.
  - FIX→DONE.
  - DONE→IDLE.
- **LN2DIV.** Restoring unsigned division `LN2_FX / S`, 16 bits, one quotient bit per cycle. On a nonzero result, write `q_ln2` and `S` into the one-entry cache and set the cache valid bit.
- **QDIV.** Restoring unsigned division `(-q) / q_ln2`, 32 bits, one bit per cycle, giving `zq = floor(-q / q_ln2)`.
- **FIX.**
  - If `zq > Z_MAX`: `z = Z_MAX`, `p = 0`, `sat = 1`.
  - Otherwise: `z = zq`, `p = q + zq*q_ln2`, computed at 48-bit internal width and truncated to `WQ`.
- **Outputs.**
  - On an error: `q_out` = clamped `q`, `z_out = 0`, `err = 1`, `S_out = S`.
  - `q_out`, `S_out`, `z_out`, `err` and `sat` update on entry to DONE and hold until the next `start` is accepted.
  - `err` and `sat` clear on acceptance.
- **Ignored starts.** `start` while `busy` is ignored, including during the DONE cycle. It is not queued.
- **Reset.** Reset mid-operation returns to IDLE next edge, zeroes all outputs, and invalidates the cache.

## Timing
- All outputs reset to 0.
- Cycle 0 is the edge that samples `start`. `done` is high in the following cycle:
  - cycle 50 on a cache miss: LN2DIV 1–16, QDIV 17–48, FIX 49, DONE 50;
  - cycle 34 on a cache hit;
  - cycle 1 for `S<=0`;
  - cycle 17 for `q_ln2==0`.
- `busy` is high in cycles 1 through the DONE cycle inclusive.
- Earliest next accepted `start` is the cycle after DONE.
- Outputs are valid in the same cycle as `done`, so the polynomial may sample `q_out`/`S_out` on its `start`.

## Structure
- **Package `int_exp_pkg`** holds:
  - the state enum;
  - `LN2_FX` and `Z_MAX` defaults;
  - the division width constants (16, 32).
- **Sub-module `seq_udiv`**, parameterised width N:
  - `load` / `busy` / `valid` handshake, N-cycle restoring divider;
  - one instance, time-shared between LN2DIV and QDIV.
- **Top level** holds the FSM, cache, FIX multiply-add and output registers.

## Test plan
- S=16, q=-100, cold cache → `done` at cycle 50; q_ln2=11, z_out=9, q_out=-1, err=0, sat=0, S_out=16.
- Back-to-back S=16, q=-25 → cache hit, `done` at cycle 34; z_out=2, q_out=-3.
- S=16, q=+5 → clamped; z_out=0, q_out=0; `done` at cycle 34 (cache hit).
- S=16, q=-1000 → zq=90 > 30; z_out=30, q_out=0, sat=1.
- S=200 → q_ln2=0; err=1 with `done` at cycle 17, q_out=q, z_out=0, cache stays invalid. Then S=0 → err=1 with `done` at cycle 1.
- Reset asserted in cycle 20 of a cold run:
  - required: no `done` pulse, all outputs 0, `busy` 0 the next cycle;
  - then the next S=16 request takes 50 cycles (cache invalidated).
  - Also: `start` pulsed during busy → ignored, exactly one `done` observed.

Source files
------------

// File: rtl/int_exp_pkg.sv
// rtl/int_exp_pkg.sv - shared types and constants for the integer exp range-reduction front end
package int_exp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LN2DIV,
        ST_QDIV,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam int LN2_FX_DEF = 177;
    localparam int Z_MAX_DEF  = 30;
    localparam int LN2_DIV_W  = 16;
    localparam int Q_DIV_W    = 32;

endpackage

// File: rtl/seq_udiv.sv
// rtl/seq_udiv.sv - restoring unsigned divider, one quotient bit per cycle, variable iteration count
module seq_udiv #(
    parameter int N  = 32,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] iters,
    input  logic [N-1:0]  dividend,
    input  logic [N-1:0]  divisor,
    output logic          busy,
    output logic          valid,
    output logic [N-1:0]  quotient
);

    logic [N-1:0]  rem, quo, dsr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  src_rem, src_quo, src_div;
    logic [N:0]    trial, diff;
    logic          ge;
    logic [N-1:0]  rem_n, quo_n;

    // The load cycle already performs the first iteration, so a shorter division
    // is run by left-aligning the dividend and stopping early.
    always_comb begin
        src_rem = load ? '0 : rem;
        src_quo = load ? dividend : quo;
        src_div = load ? divisor : dsr;
        trial   = {src_rem, src_quo[N-1]};
        diff    = trial - {1'b0, src_div};
        ge      = trial >= {1'b0, src_div};
        rem_n   = ge ? diff[N-1:0] : trial[N-1:0];
        quo_n   = {src_quo[N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            rem   <= rem_n;
            quo   <= quo_n;
            dsr   <= divisor;
            cnt   <= iters - CW'(1);
            valid <= (iters == CW'(1));
        end else if (cnt != '0) begin
            rem   <= rem_n;
            quo   <= quo_n;
            cnt   <= cnt - CW'(1);
            valid <= (cnt == CW'(1));
        end else begin
            valid <= 1'b0;
        end
    end

    assign busy     = (cnt != '0);
    assign quotient = quo;

endmodule

// File: rtl/integer_exp_range_reduce.sv
// rtl/integer_exp_range_reduce.sv - decomposes q = p - z*floor(LN2_FX/S) for the softmax integer exp
module integer_exp_range_reduce
    import int_exp_pkg::*;
#(
    parameter int WQ     = 32,
    parameter int WS     = 16,
    parameter int LN2_FX = LN2_FX_DEF,
    parameter int Z_MAX  = Z_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [WQ-1:0] q,
    input  logic signed [WS-1:0] S,
    output logic signed [WQ-1:0] q_out,
    output logic signed [WS-1:0] S_out,
    output logic [4:0]           z_out,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic                 sat
);

    localparam int DW = Q_DIV_W;
    localparam int CW = $clog2(DW + 1);

    state_t                 state, state_n;
    logic signed [WQ-1:0]   q_reg, q_clamp, q_src;
    logic signed [WS-1:0]   s_reg, cache_s;
    logic [LN2_DIV_W-1:0]   qln2_reg, cache_ln2, ln2_q;
    logic                   cache_valid, s_bad, hit, zq_big;
    logic                   div_load, div_busy, div_valid;
    logic [CW-1:0]          div_iters;
    logic [DW-1:0]          div_dividend, div_divisor, div_quo, zq, neg_q;

    assign q_clamp = q[WQ-1] ? q : '0;
    assign s_bad   = S[WS-1] || (S == '0);
    assign hit     = cache_valid && (S == cache_s);
    assign zq      = div_quo;
    assign ln2_q   = div_quo[LN2_DIV_W-1:0];
    assign zq_big  = zq > DW'(Z_MAX);
    assign q_src   = (state == ST_IDLE) ? q_clamp : q_reg;
    assign neg_q   = DW'(-q_src);

    seq_udiv #(.N(DW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .iters    (div_iters),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .valid    (div_valid),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        div_load     = 1'b0;
        div_iters    = '0;
        div_dividend = '0;
        div_divisor  = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (s_bad) begin
                        state_n = ST_DONE;
                    end else if (hit) begin
                        state_n      = ST_QDIV;
                        div_load     = 1'b1;
                        div_iters    = CW'(Q_DIV_W);
                        div_dividend = neg_q;
                        div_divisor  = DW'(cache_ln2);
                    end else begin
                        state_n      = ST_LN2DIV;
                        div_load     = 1'b1;
                        div_iters    = CW'(LN2_DIV_W);
                        div_dividend = DW'(LN2_FX) << LN2_DIV_W;
                        div_divisor  = DW'($unsigned(S));
                    end
                end
            end
            ST_LN2DIV: begin
                if (div_valid && !div_busy) begin
                    if (ln2_q == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n      = ST_QDIV;
                        div_load     = 1'b1;
                        div_iters    = CW'(Q_DIV_W);
                        div_dividend = neg_q;
                        div_divisor  = DW'(ln2_q);
                    end
                end
            end
            ST_QDIV: begin
                if (div_valid && !div_busy) state_n = ST_FIX;
            end
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            s_reg       <= '0;
            qln2_reg    <= '0;
            cache_valid <= 1'b0;
            cache_s     <= '0;
            cache_ln2   <= '0;
            q_out       <= '0;
            S_out       <= '0;
            z_out       <= '0;
            err         <= 1'b0;
            sat         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_reg <= q_clamp;
                        s_reg <= S;
                        err   <= 1'b0;
                        sat   <= 1'b0;
                        if (s_bad) begin
                            q_out <= q_clamp;
                            S_out <= S;
                            z_out <= '0;
                            err   <= 1'b1;
                        end else if (hit) begin
                            qln2_reg <= cache_ln2;
                        end
                    end
                end
                ST_LN2DIV: begin
                    if (div_valid && !div_busy) begin
                        if (ln2_q == '0) begin
                            q_out <= q_reg;
                            S_out <= s_reg;
                            z_out <= '0;
                            err   <= 1'b1;
                        end else begin
                            qln2_reg    <= ln2_q;
                            cache_valid <= 1'b1;
                            cache_s     <= s_reg;
                            cache_ln2   <= ln2_q;
                        end
                    end
                end
                ST_FIX: begin
                    S_out <= s_reg;
                    if (zq_big) begin
                        z_out <= 5'(Z_MAX);
                        q_out <= '0;
                        sat   <= 1'b1;
                    end else begin
                        // 48-bit multiply-add so zq*q_ln2 cannot wrap before the sum
                        z_out <= zq[4:0];
                        q_out <= WQ'({{(48-WQ){q_reg[WQ-1]}}, q_reg} + 48'(zq) * 48'(qln2_reg));
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state == ST_DONE);
    assign busy = (state != ST_IDLE);

endmodule
